// File: rtl/anim_sprite_engine.sv
// Animated sprite: plays FRAMES frames from a frame-packed ROM at a latched position, one-shot and retriggerable.
// Scan-to-visible/color_idx latency is 3 cycles, one pixel per cycle, no stalls; SPRITE_MIRROR_EN adds hflip.
module anim_sprite_engine #(
  parameter int SPRITE_W    = 64,
  parameter int SPRITE_H    = 64,
  parameter int FRAMES      = 8,
  parameter int FRAME_TICKS = 4,
  parameter int COLOR_BITS  = 6,
  parameter int TRANSPARENT = 0,
  parameter int ADDR_W      = $clog2(FRAMES*SPRITE_W*SPRITE_H)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  frame_tick,
  input  logic                  trigger,
  input  logic [9:0]            posx,
  input  logic [9:0]            posy,
`ifdef SPRITE_MIRROR_EN
  input  logic                  hflip,
`endif
  input  logic [9:0]            xcurrent,
  input  logic [9:0]            ycurrent,
  output logic [ADDR_W-1:0]     rom_addr,
  input  logic [COLOR_BITS-1:0] rom_data,
  output logic                  visible,
  output logic [COLOR_BITS-1:0] color_idx,
  output logic                  busy,
  output logic                  done
);

  localparam int XW         = $clog2(SPRITE_W);
  localparam int YW         = $clog2(SPRITE_H);
  localparam int FW         = (FRAMES > 1) ? $clog2(FRAMES) : 1;
  localparam int TW         = (FRAME_TICKS > 1) ? $clog2(FRAME_TICKS) : 1;
  localparam int FRAME_SIZE = SPRITE_W * SPRITE_H;

  typedef enum logic {IDLE, PLAY} state_t;

  state_t                state_q, state_d;
  logic [FW-1:0]         frame_q, frame_d;
  logic [TW-1:0]         tick_cnt_q, tick_cnt_d;
  logic [9:0]            posx_q, posx_d;
  logic [9:0]            posy_q, posy_d;
  logic                  done_q, done_d;
`ifdef SPRITE_MIRROR_EN
  logic                  hflip_q, hflip_d;
`endif
  logic [ADDR_W-1:0]     rom_addr_q, rom_addr_d;
  logic                  hit1_q, hit1_d, hit2_q, hit2_d;
  logic                  busy1_q, busy1_d, busy2_q, busy2_d;
  logic                  visible_q, visible_d;
  logic [COLOR_BITS-1:0] color_q, color_d;

  logic                  hit;
  logic [XW-1:0]         dx;
  logic [YW-1:0]         dy;

  // 11-bit compares so a sprite hanging past 1023 is clipped, not wrapped
  always_comb begin
    hit = ({1'b0, xcurrent} >= {1'b0, posx_q}) &&
          ({1'b0, xcurrent} <  ({1'b0, posx_q} + 11'(SPRITE_W))) &&
          ({1'b0, ycurrent} >= {1'b0, posy_q}) &&
          ({1'b0, ycurrent} <  ({1'b0, posy_q} + 11'(SPRITE_H)));
    dx  = xcurrent[XW-1:0] - posx_q[XW-1:0];
    dy  = ycurrent[YW-1:0] - posy_q[YW-1:0];
`ifdef SPRITE_MIRROR_EN
    if (hflip_q) dx = ~dx;
`endif
  end

  always_comb begin
    state_d    = state_q;
    frame_d    = frame_q;
    tick_cnt_d = tick_cnt_q;
    posx_d     = posx_q;
    posy_d     = posy_q;
    done_d     = 1'b0;
`ifdef SPRITE_MIRROR_EN
    hflip_d    = hflip_q;
`endif
    // a trigger outranks the final tick, so a restart never emits done
    if (trigger) begin
      state_d    = PLAY;
      frame_d    = '0;
      tick_cnt_d = '0;
      posx_d     = posx;
      posy_d     = posy;
`ifdef SPRITE_MIRROR_EN
      hflip_d    = hflip;
`endif
    end else if (state_q == PLAY && frame_tick) begin
      if (tick_cnt_q != TW'(FRAME_TICKS-1)) begin
        tick_cnt_d = tick_cnt_q + TW'(1);
      end else if (frame_q == FW'(FRAMES-1)) begin
        state_d    = IDLE;
        tick_cnt_d = '0;
        done_d     = 1'b1;
      end else begin
        tick_cnt_d = '0;
        frame_d    = frame_q + FW'(1);
      end
    end
  end

  always_comb begin
    rom_addr_d = rom_addr_q;
    if (hit) rom_addr_d = ADDR_W'(frame_q) * ADDR_W'(FRAME_SIZE) + ADDR_W'({dy, dx});
    hit1_d    = hit;
    busy1_d   = (state_q == PLAY);
    hit2_d    = hit1_q;
    busy2_d   = busy1_q;
    visible_d = busy2_q && hit2_q && (rom_data != COLOR_BITS'(TRANSPARENT));
    color_d   = visible_d ? rom_data : '0;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      frame_q    <= '0;
      tick_cnt_q <= '0;
      posx_q     <= '0;
      posy_q     <= '0;
      done_q     <= 1'b0;
`ifdef SPRITE_MIRROR_EN
      hflip_q    <= 1'b0;
`endif
      rom_addr_q <= '0;
      hit1_q     <= 1'b0;
      hit2_q     <= 1'b0;
      busy1_q    <= 1'b0;
      busy2_q    <= 1'b0;
      visible_q  <= 1'b0;
      color_q    <= '0;
    end else begin
      state_q    <= state_d;
      frame_q    <= frame_d;
      tick_cnt_q <= tick_cnt_d;
      posx_q     <= posx_d;
      posy_q     <= posy_d;
      done_q     <= done_d;
`ifdef SPRITE_MIRROR_EN
      hflip_q    <= hflip_d;
`endif
      rom_addr_q <= rom_addr_d;
      hit1_q     <= hit1_d;
      hit2_q     <= hit2_d;
      busy1_q    <= busy1_d;
      busy2_q    <= busy2_d;
      visible_q  <= visible_d;
      color_q    <= color_d;
    end
  end

  assign rom_addr  = rom_addr_q;
  assign visible   = visible_q;
  assign color_idx = color_q;
  assign busy      = (state_q == PLAY);
  assign done      = done_q;

endmodule
